// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : noc_pkg
// Description : Shared port indices, one-hot port encodings and round-robin
//               helper functions for the 3-port (L/W/S) router switch stage.
// Revision    : 1.0  initial release
// ============================================================================
package noc_pkg;

  // Bit positions of each input inside a 3-bit request/grant vector
  localparam int IDX_L = 2;
  localparam int IDX_W = 1;
  localparam int IDX_S = 0;

  // One-hot encodings of each input, plus the "no grant" value
  localparam logic [2:0] OH_L = 3'b100;
  localparam logic [2:0] OH_W = 3'b010;
  localparam logic [2:0] OH_S = 3'b001;
  localparam logic [2:0] NONE = 3'b000;

  // Rotate a one-hot vector right by one; 001 wraps to 100
  function automatic logic [2:0] rot_r3(input logic [2:0] v);
    return {v[0], v[2:1]};
  endfunction

  // Pick the first requester starting at ptr and walking right with wrap.
  // ptr=100 -> L,W,S ; ptr=010 -> W,S,L ; ptr=001 -> S,L,W
  function automatic logic [2:0] rr_pick(input logic [2:0] req,
                                         input logic [2:0] ptr);
    logic [2:0] cand;
    logic [2:0] pick;
    pick = NONE;
    cand = ptr;
    for (int i = 0; i < 3; i++) begin
      if ((pick == NONE) && ((req & cand) != NONE)) begin
        pick = cand;
      end
      cand = rot_r3(cand);
    end
    return pick;
  endfunction

endpackage : noc_pkg
`default_nettype wire

// File: rtl/rr_arb3.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb3
// Description : 3-input one-hot round-robin arbiter for one output port.
//               Keeps a rotating priority pointer, holds a winner while the
//               output cannot accept, and counts stall cycles (saturating).
// Revision    : 1.0  initial release
// ============================================================================
module rr_arb3
  import noc_pkg::*;
#(
  parameter int         STALL_W = 8,
  parameter logic [2:0] PTR_RST = 3'b100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic               i_accept,
  input  logic [2:0]         i_req,
  output logic [2:0]         o_grant,
  output logic [STALL_W-1:0] o_stall_cnt
);

  localparam logic [STALL_W-1:0] C_STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_W-1:0] C_STALL_MAX = {STALL_W{1'b1}};

  logic [2:0]         r_ptr;
  logic [2:0]         r_lock;
  logic [STALL_W-1:0] r_stall;

  logic               w_lock_hit;
  logic [2:0]         w_grant;
  logic               w_accepted;

  // A stored lock only counts while its requester is still asking
  assign w_lock_hit = ((r_lock & i_req) != NONE);

  // Grant selection: locked winner first, otherwise round-robin from ptr
  always_comb begin
    w_grant = NONE;
    if (rst_n && i_en) begin
      if (w_lock_hit) begin
        w_grant = r_lock;
      end else begin
        w_grant = rr_pick(i_req, r_ptr);
      end
    end
  end

  assign w_accepted = (w_grant != NONE) && i_accept;

  // Pointer, lock and stall state; all frozen while arbitration is disabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr   <= PTR_RST;
      r_lock  <= NONE;
      r_stall <= '0;
    end else if (i_en) begin
      if (w_accepted) begin
        r_ptr   <= rot_r3(w_grant);
        r_lock  <= NONE;
        r_stall <= '0;
      end else begin
        // Unaccepted grant becomes the lock; no grant clears the lock
        r_lock <= w_grant;
        if ((i_req != NONE) && (r_stall != C_STALL_MAX)) begin
          r_stall <= r_stall + C_STALL_ONE;
        end
      end
    end
  end

  assign o_grant     = w_grant;
  assign o_stall_cnt = r_stall;

endmodule : rr_arb3
`default_nettype wire

// File: rtl/outport_arbiter02.sv
`default_nettype none
// ============================================================================
// Module      : outport_arbiter02
// Description : Per-output round-robin switch arbiter for the L/W/S router
//               switch stage. Outputs are arbitrated in the fixed order
//               W, S, L; an input granted on an earlier output is masked from
//               the later ones in the same cycle.
// Revision    : 1.0  initial release
// ============================================================================
module outport_arbiter02
  import noc_pkg::*;
#(
  parameter int         STALL_W = 8,
  parameter logic [2:0] PTR_RST = 3'b100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arb_en,
  input  logic [2:0]         req_L,
  input  logic [2:0]         req_W,
  input  logic [2:0]         req_S,
  input  logic               W_full,
  input  logic               S_full,
  output logic [2:0]         L_arb_res,
  output logic [2:0]         W_arb_res,
  output logic [2:0]         S_arb_res,
  output logic [STALL_W-1:0] L_stall_cnt,
  output logic [STALL_W-1:0] W_stall_cnt,
  output logic [STALL_W-1:0] S_stall_cnt
);

  logic [2:0] w_req_s_m;
  logic [2:0] w_req_l_m;
  logic [2:0] w_grant_w;
  logic [2:0] w_grant_s;
  logic [2:0] w_grant_l;

  // Exclusivity chain: S sees requests not already won on W,
  // L sees requests not already won on W or S
  assign w_req_s_m = req_S & ~w_grant_w;
  assign w_req_l_m = req_L & ~(w_grant_w | w_grant_s);

  rr_arb3 #(
    .STALL_W (STALL_W),
    .PTR_RST (PTR_RST)
  ) u_arb_w (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (arb_en),
    .i_accept    (~W_full),
    .i_req       (req_W),
    .o_grant     (w_grant_w),
    .o_stall_cnt (W_stall_cnt)
  );

  rr_arb3 #(
    .STALL_W (STALL_W),
    .PTR_RST (PTR_RST)
  ) u_arb_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (arb_en),
    .i_accept    (~S_full),
    .i_req       (w_req_s_m),
    .o_grant     (w_grant_s),
    .o_stall_cnt (S_stall_cnt)
  );

  // The local (L) output never back-pressures
  rr_arb3 #(
    .STALL_W (STALL_W),
    .PTR_RST (PTR_RST)
  ) u_arb_l (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (arb_en),
    .i_accept    (1'b1),
    .i_req       (w_req_l_m),
    .o_grant     (w_grant_l),
    .o_stall_cnt (L_stall_cnt)
  );

  assign W_arb_res = w_grant_w;
  assign S_arb_res = w_grant_s;
  assign L_arb_res = w_grant_l;

endmodule : outport_arbiter02
`default_nettype wire
